// File: rtl/bpred_pkg.sv
// bpred_pkg: counter encodings and the gshare index function shared by the branch predictor blocks.
package bpred_pkg;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;
  localparam logic [1:0] CTR_RESET = CTR_WT;

  // Word address XOR history; callers zero-extend inputs and keep the low index bits.
  function automatic logic [31:0] bpred_index(input logic [31:0] pc, input logic [31:0] history);
    return (pc >> 2) ^ history;
  endfunction

endpackage

// File: rtl/sat_counter_2b.sv
// sat_counter_2b: next state of a 2-bit saturating direction counter.
module sat_counter_2b
  import bpred_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       taken,
  output logic [1:0] next_ctr
);

  always_comb
    next_ctr = taken ? ((ctr == CTR_ST)  ? ctr : ctr + 2'd1)
                     : ((ctr == CTR_SNT) ? ctr : ctr - 2'd1);

endmodule

// File: rtl/gshare_counter_table.sv
// gshare_counter_table: gshare pattern history table with DEC-side prediction,
// write-first bypass and EX-side training of 2-bit saturating counters.
module gshare_counter_table
  import bpred_pkg::*;
#(
  parameter int BPRED_WIDTH = 8,
  parameter int PC_WIDTH    = 32
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset,
  input  logic                   i_DEC_Is_Branch,
  input  logic [PC_WIDTH-1:0]    i_DEC_PC,
  input  logic [BPRED_WIDTH-1:0] i_Global_History,
  input  logic                   i_Stall,
  input  logic                   i_Flush,
  input  logic                   i_ALU_Branch_Valid,
  input  logic                   i_ALU_Branch_Outcome,
  output logic                   o_Prediction,
  output logic                   o_EX_Mispredict
);

  localparam int ENTRIES = 1 << BPRED_WIDTH;

  logic [1:0]             tbl [ENTRIES];
  logic [31:0]            idx_wide;
  logic [BPRED_WIDTH-1:0] dec_idx;
  logic [BPRED_WIDTH-1:0] ex_idx;
  logic                   ex_valid;
  logic                   ex_pred;
  logic                   commit;
  logic [1:0]             upd_ctr;
  logic [1:0]             byp_ctr;
  logic [1:0]             eff_ctr;
  logic                   unused_bits;

  assign idx_wide    = bpred_index(32'(i_DEC_PC), 32'(i_Global_History));
  assign dec_idx     = idx_wide[BPRED_WIDTH-1:0];
  assign unused_bits = ^{idx_wide[31:BPRED_WIDTH], eff_ctr[0]};
  assign commit      = i_ALU_Branch_Valid & ex_valid;

  sat_counter_2b u_upd (
    .ctr      (tbl[ex_idx]),
    .taken    (i_ALU_Branch_Outcome),
    .next_ctr (upd_ctr)
  );

  sat_counter_2b u_byp (
    .ctr      (tbl[dec_idx]),
    .taken    (i_ALU_Branch_Outcome),
    .next_ctr (byp_ctr)
  );

  // Write-first: an aliased DEC lookup sees the counter being committed this cycle.
  assign eff_ctr         = (commit && ex_idx == dec_idx) ? byp_ctr : tbl[dec_idx];
  assign o_Prediction    = eff_ctr[1];
  assign o_EX_Mispredict = commit & (ex_pred ^ i_ALU_Branch_Outcome);

  always_ff @(posedge i_Clk or negedge i_Reset) begin
    if (!i_Reset) begin
      for (int i = 0; i < ENTRIES; i++) tbl[i] <= CTR_RESET;
    end else if (commit) begin
      tbl[ex_idx] <= upd_ctr;
    end
  end

  // A stalled EX branch is consumed once: training clears valid but holds the other fields.
  always_ff @(posedge i_Clk or negedge i_Reset) begin
    if (!i_Reset) begin
      ex_valid <= 1'b0;
      ex_idx   <= '0;
      ex_pred  <= 1'b0;
    end else if (i_Flush) begin
      ex_valid <= 1'b0;
    end else if (i_Stall) begin
      ex_valid <= ex_valid & ~commit;
    end else begin
      ex_valid <= i_DEC_Is_Branch;
      ex_idx   <= dec_idx;
      ex_pred  <= o_Prediction;
    end
  end

endmodule

// File: tb/tb_gshare_counter_table.sv
// tb_gshare_counter_table: directed checks of prediction, bypass, training, stall, flush and reset.
module tb_gshare_counter_table;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        br;
  logic [31:0] pc;
  logic [7:0]  ghr;
  logic        stall;
  logic        flush;
  logic        alu_v;
  logic        alu_o;
  logic        pred;
  logic        misp;
  int          total = 0;
  int          fails = 0;

  gshare_counter_table #(.BPRED_WIDTH(8), .PC_WIDTH(32)) dut (
    .i_Clk                (clk),
    .i_Reset              (rst_n),
    .i_DEC_Is_Branch      (br),
    .i_DEC_PC             (pc),
    .i_Global_History     (ghr),
    .i_Stall              (stall),
    .i_Flush              (flush),
    .i_ALU_Branch_Valid   (alu_v),
    .i_ALU_Branch_Outcome (alu_o),
    .o_Prediction         (pred),
    .o_EX_Mispredict      (misp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic b, input logic [31:0] p, input logic [7:0] g,
                       input logic av, input logic ao);
    br = b; pc = p; ghr = g; alu_v = av; alu_o = ao;
  endtask

  initial begin
    rst_n = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(0, 32'h0, 8'h0, 0, 0);
    #2 rst_n = 1'b0;
    tick(); tick();
    check("rst_ex_valid", dut.ex_valid, 0);
    check("rst_ex_idx", dut.ex_idx, 0);
    check("rst_ex_pred", dut.ex_pred, 0);
    check("rst_misp", misp, 0);
    check("rst_pred", pred, 1);
    rst_n = 1'b1;
    // first branch: idx 0x10 ^ 0xFF = 0xEF
    drive(1, 32'h40, 8'hFF, 0, 0); #1;
    check("t1_pred", pred, 1);
    tick();
    check("t1_ex_valid", dut.ex_valid, 1);
    check("t1_ex_idx", dut.ex_idx, 8'hEF);
    check("t1_ex_pred", dut.ex_pred, 1);
    drive(1, 32'h40, 8'hFF, 1, 0); #1;
    check("nt1_misp", misp, 1);
    check("nt1_byp_pred", pred, 0);
    tick();
    check("nt1_ctr", dut.tbl[8'hEF], 2'b01);
    check("nt1_ex_pred", dut.ex_pred, 0);
    drive(1, 32'h40, 8'hFF, 1, 0); #1;
    check("nt2_misp", misp, 0);
    check("nt2_pred", pred, 0);
    tick();
    check("nt2_ctr", dut.tbl[8'hEF], 2'b00);
    drive(0, 32'h40, 8'hFF, 1, 0); #1;
    check("nt3_misp", misp, 0);
    tick();
    drive(0, 32'h40, 8'hFF, 0, 0); #1;
    check("sat_pred", pred, 0);
    check("sat_ctr", dut.tbl[8'hEF], 2'b00);
    // bypass on idx 0x22: train to 01, then taken while an aliased DEC lookup reads it
    drive(1, 32'h88, 8'h00, 0, 0);
    tick();
    drive(1, 32'h88, 8'h00, 1, 0); #1;
    check("byp_setup_misp", misp, 1);
    tick();
    check("byp_setup_ctr", dut.tbl[8'h22], 2'b01);
    drive(1, 32'h80, 8'h02, 1, 1); #1;
    check("byp_pred", pred, 1);
    check("byp_misp", misp, 1);
    tick();
    check("byp_ex_pred", dut.ex_pred, 1);
    check("byp_ex_idx", dut.ex_idx, 8'h22);
    check("byp_ctr", dut.tbl[8'h22], 2'b10);
    // stall holds EX branch on 0x22 while DEC shows 0x05
    stall = 1'b1;
    drive(1, 32'h14, 8'h00, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_idx", dut.ex_idx, 8'h22);
      check("stall_pred", dut.ex_pred, 1);
      check("stall_valid", dut.ex_valid, 1);
    end
    drive(1, 32'h14, 8'h00, 1, 1); #1;
    check("stall_upd_misp", misp, 0);
    tick();
    check("stall_upd_valid", dut.ex_valid, 0);
    check("stall_upd_idx", dut.ex_idx, 8'h22);
    check("stall_upd_ctr", dut.tbl[8'h22], 2'b11);
    drive(1, 32'h14, 8'h00, 1, 0); #1;
    check("stall_ignored_misp", misp, 0);
    tick();
    check("stall_once_ctr", dut.tbl[8'h22], 2'b11);
    stall = 1'b0;
    drive(1, 32'h88, 8'h00, 0, 0);
    tick();
    drive(0, 32'h88, 8'h00, 1, 0); #1;
    check("stall_probe_pred", pred, 1);
    check("stall_probe_misp", misp, 1);
    tick();
    // flush beats stall and drops the capture
    drive(1, 32'hCC, 8'h00, 0, 0);
    tick();
    check("flush_pre_valid", dut.ex_valid, 1);
    flush = 1'b1; stall = 1'b1;
    tick();
    check("flush_valid", dut.ex_valid, 0);
    flush = 1'b0; stall = 1'b0;
    drive(0, 32'hCC, 8'h00, 1, 0); #1;
    check("flush_misp", misp, 0);
    tick();
    drive(0, 32'hCC, 8'h00, 0, 0); #1;
    check("flush_ctr", dut.tbl[8'h33], 2'b10);
    check("flush_pred", pred, 1);
    // train 0x40 to 11, leave a pending update, then reset mid-cycle
    drive(1, 32'h100, 8'h00, 0, 0);
    tick();
    drive(1, 32'h100, 8'h00, 1, 1);
    tick();
    drive(0, 32'h100, 8'h00, 1, 0); #1;
    check("pre_rst_ctr", dut.tbl[8'h40], 2'b11);
    check("pre_rst_misp", misp, 1);
    rst_n = 1'b0; #1;
    check("mid_rst_valid", dut.ex_valid, 0);
    check("mid_rst_misp", misp, 0);
    check("mid_rst_ctr40", dut.tbl[8'h40], 2'b10);
    check("mid_rst_pred40", pred, 1);
    pc = 32'h40; ghr = 8'hFF; #1;
    check("mid_rst_ctrEF", dut.tbl[8'hEF], 2'b10);
    check("mid_rst_predEF", pred, 1);
    pc = 32'h88; ghr = 8'h00; #1;
    check("mid_rst_ctr22", dut.tbl[8'h22], 2'b10);
    check("mid_rst_pred22", pred, 1);
    tick();
    rst_n = 1'b1;
    drive(0, 32'h0, 8'h00, 0, 0);
    tick();
    check("post_rst_valid", dut.ex_valid, 0);
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule

// File: doc/gshare_counter_table.md
Name: gshare_counter_table

Overview:
- Pattern history table feeding the branch predictor.
- The table index is the DEC-stage PC word address XORed with the global history register output.
- Provides the combinational taken/not-taken prediction that is shifted into the GHR.
- Captures the index and prediction into an EX-side register, then trains the 2-bit saturating counter when the branch resolves in EX.

Parameters:
- BPRED_WIDTH, 8: index width and GHR width; the table holds 2^BPRED_WIDTH counters.
- PC_WIDTH, 32: width of the program counter.

Ports:
- i_Clk  in  1  clock.
- i_Reset  in  1  reset, asynchronous, active-low.
- i_DEC_Is_Branch  in  1  instruction in DEC is a conditional branch.
- i_DEC_PC  in  PC_WIDTH  PC of the DEC instruction.
- i_Global_History  in  BPRED_WIDTH  current GHR value.
- i_Stall  in  1  pipeline stall; holds the EX capture register.
- i_Flush  in  1  squash; invalidates the DEC→EX capture.
- i_ALU_Branch_Valid  in  1  a branch is resolving in EX this cycle.
- i_ALU_Branch_Outcome  in  1  resolved direction (1 = taken).
- o_Prediction  out  1  prediction for the DEC branch (combinational).
- o_EX_Mispredict  out  1  EX resolution differs from the prediction made for it (combinational).

Behaviour:
- Index: dec_idx = i_DEC_PC[BPRED_WIDTH+1:2] ^ i_Global_History. PC bits [1:0] are ignored.
- Table: 2^BPRED_WIDTH entries of 2 bits each.
  - Encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
  - On reset (i_Reset=0, asynchronous), every entry is set to 2'b10, weakly taken, matching the GHR's all-taken reset.
- Prediction: o_Prediction = bit[1] of the effective counter at dec_idx. It is valid every cycle and only meaningful while i_DEC_Is_Branch=1.
- Read-during-write bypass: if an update commits this cycle to ex_idx == dec_idx, the effective counter is the post-update value (write-first), so back-to-back aliased branches see fresh state.
- EX capture register (ex_valid, ex_idx, ex_pred), clocked on posedge i_Clk:
  - i_Flush=1: ex_valid←0. Flush has priority over stall.
  - else i_Stall=1: hold all fields.
  - else: ex_valid←i_DEC_Is_Branch; ex_idx←dec_idx; ex_pred←o_Prediction.
- Latency: prediction is 0 cycles (DEC); training commits at the posedge ending the EX cycle, exactly 1 cycle after capture.
- Update: the table commits only when i_ALU_Branch_Valid && ex_valid.
  - Outcome 1: counter+1, saturating at 11.
  - Outcome 0: counter-1, saturating at 00.
  - i_ALU_Branch_Valid with ex_valid=0 is ignored; no table write.
- Update and stall: an update commits even while i_Stall=1. EX consumes the branch once, so a held EX branch must not be re-presented. Consequently, when training commits under stall, the capture register clears ex_valid (stall-hold applies to the other fields only).
- o_EX_Mispredict = i_ALU_Branch_Valid & ex_valid & (ex_pred ^ i_ALU_Branch_Outcome).
- Reset values:
  - ex_valid=0, ex_idx=0, ex_pred=0.
  - o_EX_Mispredict=0.
  - o_Prediction=1, since every counter resets to 10.
- Reset mid-operation: any pending EX update is dropped; the table returns to all 10.
- Simultaneous DEC branch and EX update: capture and training occur on the same edge. The captured ex_pred uses the bypassed value.

Decomposition:
- Shared package bpred_pkg holds:
  - counter encodings (CTR_SNT=2'b00, CTR_WNT=2'b01, CTR_WT=2'b10, CTR_ST=2'b11) and CTR_RESET=CTR_WT;
  - the index function (PC word slice XOR history), shared with the GHR's consumer wiring.
- One sub-module: sat_counter_2b, a pure next-state function (counter, outcome → counter'), instantiated for the update and the bypass path.
- The table array stays in this module.

Test Plan:
- Reset release, PC=0x0000_0040, GHR=0xFF, i_DEC_Is_Branch=1 → o_Prediction=1; ex_idx captured as 0x10^0xFF=0xEF.
- Same branch resolved not-taken twice → entry 0xEF goes 10→01→00; o_EX_Mispredict=1 on the first resolution and 0 on the second; the next DEC lookup of 0xEF gives o_Prediction=0. A third not-taken leaves 00 (saturation).
- Bypass: EX updates idx 0x22 from 01 to 10 (taken) while DEC looks up idx 0x22 in the same cycle → o_Prediction=1 in that cycle, and ex_pred is captured as 1.
- i_Stall=1 for 3 cycles with the branch in DEC → ex_idx/ex_pred held; a single EX update commits once, ex_valid clears, and the counter moves by exactly one step.
- i_Flush=1 with a branch in DEC, then i_ALU_Branch_Valid=1 next cycle → no table change; o_EX_Mispredict=0.
- Assert i_Reset=0 mid-stream after entries are trained to 11 → immediately ex_valid=0, o_EX_Mispredict=0, and all entries read 10 (o_Prediction=1) for three sampled indices.
